// File: rtl/otter_lsu_pkg.sv
// Shared types and helpers for the OTTER load/store unit.
package otter_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } lsu_state_t;

  localparam logic [31:0] DEF_MMIO_BASE = 32'h0001_0000;

  typedef struct packed {
    logic        rden;
    logic        we;
    logic [31:0] addr;
    logic [31:0] din;
    logic [1:0]  size;
    logic        sign;
  } mem_cmd_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return (size == SZ_BYTE) ||
           ((size == SZ_HALF) && !addr_lo[0]) ||
           ((size == SZ_WORD) && (addr_lo == 2'b00));
  endfunction

  // A split beat is always an unsigned byte; the unit does its own extension.
  function automatic mem_cmd_t beat_cmd(input logic        we,
                                        input logic [31:0] addr,
                                        input logic [31:0] wdata,
                                        input logic [1:0]  size,
                                        input logic        sign,
                                        input logic        split,
                                        input logic [1:0]  beat);
    mem_cmd_t c;
    c.rden = ~we;
    c.we   = we;
    if (split) begin
      c.addr = addr + {30'd0, beat};
      c.size = SZ_BYTE;
      c.sign = 1'b1;
      c.din  = {24'd0, wdata[{beat, 3'b000} +: 8]};
    end else begin
      c.addr = addr;
      c.size = size;
      c.sign = sign;
      c.din  = wdata;
    end
    return c;
  endfunction

endpackage

// File: rtl/otter_lsu_if.sv
// Pipeline request/response and Memory data-port-2 signals of the load/store unit.
interface otter_lsu_if;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WE;
  logic [31:0] REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic [1:0]  REQ_SIZE;
  logic        REQ_SIGN;
  logic        RSP_VALID;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;
  logic        MEM_RDEN2;
  logic        MEM_WE2;
  logic [31:0] MEM_ADDR2;
  logic [31:0] MEM_DIN2;
  logic [1:0]  MEM_SIZE;
  logic        MEM_SIGN;
  logic [31:0] MEM_DOUT2;

  modport slave (
    input  REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, REQ_SIZE, REQ_SIGN, MEM_DOUT2,
    output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
           MEM_RDEN2, MEM_WE2, MEM_ADDR2, MEM_DIN2, MEM_SIZE, MEM_SIGN
  );

  modport master (
    output REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, REQ_SIZE, REQ_SIGN, MEM_DOUT2,
    input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
           MEM_RDEN2, MEM_WE2, MEM_ADDR2, MEM_DIN2, MEM_SIZE, MEM_SIGN
  );
endinterface

// File: rtl/otter_lsu_extend.sv
// Size/sign extension of load data assembled from byte beats.
module otter_lsu_extend
  import otter_lsu_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = data_i;
    case (size_i)
      SZ_BYTE: data_o = {{24{~uns_i & data_i[7]}}, data_i[7:0]};
      SZ_HALF: data_o = {{16{~uns_i & data_i[15]}}, data_i[15:0]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/otter_lsu.sv
// Load/store unit: drives OTTER Memory data port 2, splitting misaligned RAM accesses
// into byte beats and returning a one-cycle response pulse.
module otter_lsu
  import otter_lsu_pkg::*;
#(
  parameter logic [31:0] MMIO_BASE        = DEF_MMIO_BASE,
  parameter bit          SPLIT_MISALIGNED = 1'b1
) (
  input logic        CLK,
  input logic        RST_N,
  otter_lsu_if.slave bus
);

  lsu_state_t  state_q, state_d;
  logic [1:0]  beat_q, beat_d, lim_q, lim_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, asm_q, asm_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d, we_q, we_d, split_q, split_d;
  logic        ready_q, ready_d, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  mem_cmd_t    mem_q, mem_d;

  logic [2:0]  nbytes;
  logic        aligned, req_err;
  logic [32:0] last_addr;
  logic [31:0] asm_next, ext_data;

  // 33 bits are enough to see an access running past 0xFFFF_FFFF.
  always_comb begin
    nbytes    = size_bytes(bus.REQ_SIZE);
    aligned   = is_aligned(bus.REQ_SIZE, bus.REQ_ADDR[1:0]);
    last_addr = {1'b0, bus.REQ_ADDR} + {30'd0, nbytes} - 33'd1;
    req_err   = (bus.REQ_SIZE == 2'd3) ||
                (!aligned && (!SPLIT_MISALIGNED || (last_addr >= {1'b0, MMIO_BASE})));
  end

  always_comb begin
    asm_next = asm_q;
    if (split_q) asm_next[{beat_q, 3'b000} +: 8] = bus.MEM_DOUT2[7:0];
    else         asm_next = bus.MEM_DOUT2;
  end

  otter_lsu_extend u_extend (
    .data_i (asm_next),
    .size_i (size_q),
    .uns_i  (sign_q),
    .data_o (ext_data)
  );

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    lim_d       = lim_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    asm_d       = asm_q;
    size_d      = size_q;
    sign_d      = sign_q;
    we_d        = we_q;
    split_d     = split_q;
    ready_d     = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    mem_d       = '0;
    case (state_q)
      IDLE: begin
        if (bus.REQ_VALID && ready_q) begin
          addr_d  = bus.REQ_ADDR;
          wdata_d = bus.REQ_WDATA;
          size_d  = bus.REQ_SIZE;
          sign_d  = bus.REQ_SIGN;
          we_d    = bus.REQ_WE;
          split_d = !aligned;
          beat_d  = '0;
          lim_d   = aligned ? 2'd0 : 2'(nbytes - 3'd1);
          asm_d   = '0;
          if (req_err) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d = ISSUE;
            mem_d   = beat_cmd(bus.REQ_WE, bus.REQ_ADDR, bus.REQ_WDATA, bus.REQ_SIZE,
                               bus.REQ_SIGN, !aligned, 2'd0);
          end
        end else begin
          ready_d = 1'b1;
        end
      end
      ISSUE: begin
        if (!we_q) begin
          state_d    = WAIT;
          mem_d      = mem_q;
          mem_d.rden = 1'b0;
          mem_d.we   = 1'b0;
        end else if (beat_q == lim_q) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
        end else begin
          beat_d = beat_q + 2'd1;
          mem_d  = beat_cmd(we_q, addr_q, wdata_q, size_q, sign_q, split_q, beat_q + 2'd1);
        end
      end
      WAIT: begin
        asm_d = asm_next;
        if (beat_q == lim_q) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = split_q ? ext_data : asm_next;
        end else begin
          state_d = ISSUE;
          beat_d  = beat_q + 2'd1;
          mem_d   = beat_cmd(we_q, addr_q, wdata_q, size_q, sign_q, split_q, beat_q + 2'd1);
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      lim_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      asm_q       <= '0;
      size_q      <= '0;
      sign_q      <= 1'b0;
      we_q        <= 1'b0;
      split_q     <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      mem_q       <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      lim_q       <= lim_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      asm_q       <= asm_d;
      size_q      <= size_d;
      sign_q      <= sign_d;
      we_q        <= we_d;
      split_q     <= split_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_q       <= mem_d;
    end
  end

  assign bus.REQ_READY = ready_q;
  assign bus.RSP_VALID = rsp_valid_q;
  assign bus.RSP_RDATA = rsp_rdata_q;
  assign bus.RSP_ERR   = rsp_err_q;
  assign bus.MEM_RDEN2 = mem_q.rden;
  assign bus.MEM_WE2   = mem_q.we;
  assign bus.MEM_ADDR2 = mem_q.addr;
  assign bus.MEM_DIN2  = mem_q.din;
  assign bus.MEM_SIZE  = mem_q.size;
  assign bus.MEM_SIGN  = mem_q.sign;

endmodule
